// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arbiter_rr_pkg: shared bus widths, owner encoding and active-low constants
package bus_arbiter_rr_pkg;
    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;
    localparam int WORD_ADDR_W   = 30;
    localparam int WORD_DATA_W   = 32;
    localparam logic ENABLE_     = 1'b0;
    localparam logic DISABLE_    = 1'b1;
    typedef enum logic [BUS_OWNER_W-1:0] {
        BUS_OWNER_M0 = 2'd0,
        BUS_OWNER_M1 = 2'd1,
        BUS_OWNER_M2 = 2'd2,
        BUS_OWNER_M3 = 2'd3
    } bus_owner_t;
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: four master request/bus ports plus the shared-bus outputs
interface bus_arbiter_rr_if;
    import bus_arbiter_rr_pkg::*;
    logic                   m0_req_, m1_req_, m2_req_, m3_req_;
    logic [WORD_ADDR_W-1:0] m0_addr, m1_addr, m2_addr, m3_addr;
    logic                   m0_as_, m1_as_, m2_as_, m3_as_;
    logic                   m0_rw, m1_rw, m2_rw, m3_rw;
    logic [WORD_DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
    logic                   m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [WORD_ADDR_W-1:0] s_addr;
    logic                   s_as_;
    logic                   s_rw;
    logic [WORD_DATA_W-1:0] s_wr_data;
    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_addr, m1_addr, m2_addr, m3_addr,
        output m0_as_, m1_as_, m2_as_, m3_as_,
        output m0_rw, m1_rw, m2_rw, m3_rw,
        output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
        input  s_addr, s_as_, s_rw, s_wr_data
    );
    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_addr, m1_addr, m2_addr, m3_addr,
        input  m0_as_, m1_as_, m2_as_, m3_as_,
        input  m0_rw, m1_rw, m2_rw, m3_rw,
        input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
        output s_addr, s_as_, s_rw, s_wr_data
    );
endinterface

// File: rtl/bus_arbiter_rr_rr_pick.sv
// rr_pick: round-robin scan from owner+1 over active-low requests
module rr_pick
    import bus_arbiter_rr_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] i_req_n,
    input  logic [BUS_OWNER_W-1:0]   i_owner,
    output logic [BUS_OWNER_W-1:0]   o_next_owner,
    output logic                     o_any_other_req
);
    logic [BUS_MASTER_CH-1:0] w_req;
    logic [BUS_OWNER_W-1:0]   w_o1, w_o2, w_o3;
    always_comb begin
        w_req           = ~i_req_n;
        w_o1            = i_owner + 2'd1;
        w_o2            = i_owner + 2'd2;
        w_o3            = i_owner + 2'd3;
        o_next_owner    = w_req[w_o1] ? w_o1 : w_req[w_o2] ? w_o2 : w_req[w_o3] ? w_o3 : i_owner;
        o_any_other_req = w_req[w_o1] | w_req[w_o2] | w_req[w_o3];
    end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin shared-bus arbiter with hold limit and owner mux
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_rr_if.slave  bus
);
    bus_owner_t                               r_owner;
    logic [CNT_W-1:0]                         r_hold;
    logic [BUS_MASTER_CH-1:0]                 w_req_n, w_as_n, w_rw;
    logic [BUS_MASTER_CH-1:0][WORD_ADDR_W-1:0] w_addr;
    logic [BUS_MASTER_CH-1:0][WORD_DATA_W-1:0] w_wd;
    logic [BUS_OWNER_W-1:0]                   w_next;
    logic                                     w_other, w_own_req, w_own_busy, w_sat, w_change;

    assign w_req_n = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
    assign w_as_n  = {bus.m3_as_, bus.m2_as_, bus.m1_as_, bus.m0_as_};
    assign w_rw    = {bus.m3_rw, bus.m2_rw, bus.m1_rw, bus.m0_rw};
    assign w_addr  = {bus.m3_addr, bus.m2_addr, bus.m1_addr, bus.m0_addr};
    assign w_wd    = {bus.m3_wr_data, bus.m2_wr_data, bus.m1_wr_data, bus.m0_wr_data};

    rr_pick u_pick (
        .i_req_n         (w_req_n),
        .i_owner         (r_owner),
        .o_next_owner    (w_next),
        .o_any_other_req (w_other)
    );

    // Forced rotation only between transfers: an active strobe defers it.
    always_comb begin
        w_own_req  = (w_req_n[r_owner] == ENABLE_);
        w_own_busy = (w_as_n[r_owner] == ENABLE_);
        w_sat      = (r_hold == CNT_W'(MAX_HOLD));
        w_change   = w_other && (!w_own_req || ((MAX_HOLD != 0) && w_sat && !w_own_busy));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= BUS_OWNER_M0;
            r_hold  <= '0;
        end else if (w_change) begin
            r_owner <= bus_owner_t'(w_next);
            r_hold  <= '0;
        end else begin
            r_hold  <= (w_own_req && w_other) ? (w_sat ? r_hold : r_hold + CNT_W'(1)) : '0;
        end
    end

    assign bus.m0_grnt_  = (r_owner != BUS_OWNER_M0);
    assign bus.m1_grnt_  = (r_owner != BUS_OWNER_M1);
    assign bus.m2_grnt_  = (r_owner != BUS_OWNER_M2);
    assign bus.m3_grnt_  = (r_owner != BUS_OWNER_M3);
    assign bus.s_addr    = w_addr[r_owner];
    assign bus.s_as_     = w_as_n[r_owner];
    assign bus.s_rw      = w_rw[r_owner];
    assign bus.s_wr_data = w_wd[r_owner];
endmodule
